wav_header_parser: RTL and testbench
====================================

# wav_header_parser

Snoops the HPS download byte stream (the same `ioctl` bytes written into DDRAM) and parses the RIFF/WAVE header on the fly. It publishes the PCM format fields and the DDRAM byte address and length of the `data` chunk. It sits upstream of `wave_sound`, which uses these fields for its start address, end-of-sample, loop point and rate/width configuration instead of assuming a raw headerless file.

## Interface
Parameters:
- `ADDR_W`, 25: width of the download byte address.

Ports:
- `clk_sys` in 1: system clock (24 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `i_start` in 1: one-cycle pulse at the start of a wav download (rising edge of `ioctl_download & wav_load`); clears the parser.
- `i_end` in 1: one-cycle pulse at the end of the download.
- `i_wr` in 1: byte strobe, qualified with `wav_load`.
- `i_addr` in ADDR_W: byte address of `i_data`.
- `i_data` in 8: download byte.
- `o_busy` in/out: out 1: parse in progress.
- `o_valid` out 1: header parsed and data chunk located; sticky.
- `o_error` out 3: error code; 0 means no error; sticky.
- `o_channels` out 16: channel count.
- `o_rate` out 32: sample rate in Hz.
- `o_bits` out 16: bits per sample.
- `o_data_start` out ADDR_W: address of the first sample byte.
- `o_data_len` out 32: size field of the data chunk, in bytes.

All outputs reset to 0.

## Operation
- States: IDLE, RIFF_ID, RIFF_SIZE, WAVE_ID, CK_ID, CK_SIZE, FMT_BODY, SKIP, PAD, DONE, ERR.
- IDLE:
  - `i_wr` is ignored.
  - `i_start` clears all outputs, sets `exp_addr=0` and `o_busy=1`, and moves to RIFF_ID. `i_start` is honoured in every state.
- Field assembly:
  - A 4-byte shift register assembles every field little-endian.
  - A 2-bit byte index selects the byte within the field.
  - A 32-bit `remain` counter tracks bytes left in the current chunk body.
- Byte acceptance:
  - Every accepted byte requires `i_addr == exp_addr`; `exp_addr` then increments.
  - A mismatch gives error 3.
- Header checks:
  - RIFF_ID requires bytes "RIFF"; otherwise error 1.
  - RIFF_SIZE discards 4 bytes.
  - WAVE_ID requires "WAVE"; otherwise error 2.
- CK_ID / CK_SIZE: read a 4-byte chunk id, then a 4-byte LE size. Dispatch:
  - "fmt ": if size < 16, error 4. Otherwise go to FMT_BODY with `remain=size`.
  - "data": if fmt has not been seen, error 5. Otherwise `o_data_start = exp_addr` (the address following the last size byte), `o_data_len = size`, and go to DONE.
  - Any other id: go to SKIP with `remain=size`. If size is 0, go directly to PAD/CK_ID.
- FMT_BODY:
  - Body offsets 0-1 are the format; it must equal 1 (PCM).
  - Offsets 2-3 → `o_channels`; 4-7 → `o_rate`; 14-15 → `o_bits`. The remaining bytes are skipped.
  - Validation runs when `remain` reaches 0: format≠1, channels∉{1,2} or bits∉{8,16} gives error 6. Otherwise set `fmt_seen`.
- Chunk end: when `remain` reaches 0 in SKIP or FMT_BODY:
  - Odd chunk size → PAD, which consumes 1 byte and then goes to CK_ID.
  - Even chunk size → CK_ID.
- DONE: `o_valid=1`, `o_busy=0`. All further bytes are ignored; they are sample data.
- ERR: sets `o_error`, `o_busy=0`, `o_valid=0`. It stays there until `i_start`.
- `i_end` in any state other than IDLE, DONE or ERR gives error 7 (truncated).

## Timing
- Each accepted byte is consumed in the cycle it is strobed. There is no backpressure; `i_wr` can arrive at most every cycle.
- `o_valid` rises one cycle after the strobe of the last data-size byte.
- All outputs are registered. Format fields update one cycle after their final byte.
- `o_error` is set one cycle after the offending byte or `i_end`.
- Simultaneous `i_start` and `i_wr`: `i_start` wins and the byte is dropped.
- Simultaneous `i_end` and `i_wr`: the byte is processed first. If that byte completes the data size field, the result is DONE, not error 7.
- `remain` decrement: 32-bit; a size of 0xFFFFFFFF is legal and simply skips until `i_end` arrives.
- `reset` mid-parse returns to IDLE immediately with all outputs at 0.

## Structure
- Package `wav_pkg` holds:
  - the state enum;
  - error code localparams (1 ERR_RIFF, 2 ERR_WAVE, 3 ERR_GAP, 4 ERR_FMT_SHORT, 5 ERR_NO_FMT, 6 ERR_UNSUP, 7 ERR_TRUNC);
  - FOURCC constants in received byte order: RIFF=32'h52494646, WAVE=32'h57415645, FMT=32'h666D7420, DATA=32'h64617461.
- Single module. No sub-module is needed; the LE shift register and counters are inline.

## Test plan
- Canonical 44-byte header (PCM, 2 ch, 22050 Hz, 16 bit, data size 0x1000) → `o_valid=1`, `o_channels=2`, `o_rate=22050`, `o_bits=16`, `o_data_start=44`, `o_data_len=0x1000`, `o_error=0`.
- "LIST" chunk of size 5 between fmt and data → pad byte consumed, `o_data_start=58`, `o_valid=1`.
- First bytes "RIFX" → `o_error=1`. "RIFF....WAVX" → `o_error=2`. data chunk before fmt → `o_error=5`.
- fmt with format=3 (float) or bits=24 → `o_error=6`. Address jump 10→12 → `o_error=3`.
- `i_end` after byte 30 → `o_error=7`. A following `i_start` plus a valid header → error cleared, `o_valid=1`.
- `reset` asserted at byte 20 → all outputs 0 and bytes ignored until the next `i_start`.

Source files
------------

// File: rtl/wav_pkg.sv
// Shared types and constants for the RIFF/WAVE header snooper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wav_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RIFF_ID,
    RIFF_SIZE,
    WAVE_ID,
    CK_ID,
    CK_SIZE,
    FMT_BODY,
    SKIP,
    PAD,
    DONE,
    ERR
  } state_t;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_RIFF      = 3'd1;
  localparam logic [2:0] ERR_WAVE      = 3'd2;
  localparam logic [2:0] ERR_GAP       = 3'd3;
  localparam logic [2:0] ERR_FMT_SHORT = 3'd4;
  localparam logic [2:0] ERR_NO_FMT    = 3'd5;
  localparam logic [2:0] ERR_UNSUP     = 3'd6;
  localparam logic [2:0] ERR_TRUNC     = 3'd7;

  // FOURCCs in received byte order: first byte on the wire is bits [31:24].
  localparam logic [31:0] FCC_RIFF = 32'h52494646;
  localparam logic [31:0] FCC_WAVE = 32'h57415645;
  localparam logic [31:0] FCC_FMT  = 32'h666D7420;
  localparam logic [31:0] FCC_DATA = 32'h64617461;

  // Little-endian assembled word -> received byte order.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/wav_header_parser.sv
// Snoops the download byte stream and parses the RIFF/WAVE header, publishing PCM format and data chunk location.
// Latency: each byte is consumed in its strobe cycle; outputs update one cycle after the byte that completes them.
// Backpressure: none; accepts one byte per cycle, i_start pre-empts everything.
//
// Ports: clk_sys/reset (async, active-high); i_start/i_end download framing pulses;
// i_wr/i_addr/i_data byte strobe; o_busy/o_valid/o_error status; o_channels/o_rate/o_bits
// PCM format; o_data_start/o_data_len location of the sample data.
module wav_header_parser
  import wav_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_end,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_data,
  output logic              o_busy,
  output logic              o_valid,
  output logic [2:0]        o_error,
  output logic [15:0]       o_channels,
  output logic [31:0]       o_rate,
  output logic [15:0]       o_bits,
  output logic [ADDR_W-1:0] o_data_start,
  output logic [31:0]       o_data_len
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   exp_addr, exp_nxt;
  logic [23:0]         sh, sh_nxt;        // three earlier bytes of the current field
  logic [1:0]          idx, idx_nxt;      // byte position within a 4-byte field
  logic [31:0]         remain, remain_nxt;
  logic [4:0]          off, off_nxt;      // fmt body offset, saturates at 16
  logic                odd, odd_nxt;      // current chunk size is odd -> pad byte follows
  logic [31:0]         ck_id, ck_id_nxt;
  logic [15:0]         tag, tag_nxt;
  logic                fmt_seen, fmt_seen_nxt;
  logic [2:0]          err_nxt;
  logic [15:0]         chan_nxt, bits_nxt;
  logic [31:0]         rate_nxt, len_nxt;
  logic [ADDR_W-1:0]   start_nxt;
  logic [31:0]         word;              // field value (LE) including the current byte
  logic                parsing;

  assign word    = {i_data, sh};
  assign parsing = (state != IDLE) && (state != DONE) && (state != ERR);

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath
  always_comb begin
    state_nxt    = state;
    exp_nxt      = exp_addr;
    sh_nxt       = sh;
    idx_nxt      = idx;
    remain_nxt   = remain;
    off_nxt      = off;
    odd_nxt      = odd;
    ck_id_nxt    = ck_id;
    tag_nxt      = tag;
    fmt_seen_nxt = fmt_seen;
    err_nxt      = o_error;
    chan_nxt     = o_channels;
    rate_nxt     = o_rate;
    bits_nxt     = o_bits;
    start_nxt    = o_data_start;
    len_nxt      = o_data_len;

    if (i_start) begin
      state_nxt    = RIFF_ID;
      exp_nxt      = '0;
      sh_nxt       = '0;
      idx_nxt      = '0;
      remain_nxt   = '0;
      off_nxt      = '0;
      odd_nxt      = 1'b0;
      ck_id_nxt    = '0;
      tag_nxt      = '0;
      fmt_seen_nxt = 1'b0;
      err_nxt      = ERR_NONE;
      chan_nxt     = '0;
      rate_nxt     = '0;
      bits_nxt     = '0;
      start_nxt    = '0;
      len_nxt      = '0;
    end else begin
      if (i_wr && parsing) begin
        if (i_addr != exp_addr) begin
          state_nxt = ERR;
          err_nxt   = ERR_GAP;
        end else begin
          exp_nxt = exp_addr + ADDR_W'(1);
          sh_nxt  = word[31:8];
          idx_nxt = idx + 2'd1;
          case (state)
            // Magic bytes are checked one at a time so the error lands on the offending byte.
            RIFF_ID: begin
              if (i_data != FCC_RIFF[{~idx, 3'b000} +: 8]) begin
                state_nxt = ERR;
                err_nxt   = ERR_RIFF;
              end else if (idx == 2'd3) begin
                state_nxt = RIFF_SIZE;
              end
            end
            RIFF_SIZE: if (idx == 2'd3) state_nxt = WAVE_ID;
            WAVE_ID: begin
              if (i_data != FCC_WAVE[{~idx, 3'b000} +: 8]) begin
                state_nxt = ERR;
                err_nxt   = ERR_WAVE;
              end else if (idx == 2'd3) begin
                state_nxt = CK_ID;
              end
            end
            CK_ID: begin
              if (idx == 2'd3) begin
                ck_id_nxt = bswap32(word);
                state_nxt = CK_SIZE;
              end
            end
            CK_SIZE: begin
              if (idx == 2'd3) begin
                odd_nxt    = word[0];
                remain_nxt = word;
                off_nxt    = '0;
                if (ck_id == FCC_FMT) begin
                  if (word < 32'd16) begin
                    state_nxt = ERR;
                    err_nxt   = ERR_FMT_SHORT;
                  end else begin
                    state_nxt = FMT_BODY;
                  end
                end else if (ck_id == FCC_DATA) begin
                  if (!fmt_seen) begin
                    state_nxt = ERR;
                    err_nxt   = ERR_NO_FMT;
                  end else begin
                    start_nxt = exp_addr + ADDR_W'(1);
                    len_nxt   = word;
                    state_nxt = DONE;
                  end
                end else if (word == 32'd0) begin
                  state_nxt = CK_ID;
                end else begin
                  state_nxt = SKIP;
                end
              end
            end
            FMT_BODY: begin
              case (off)
                5'd0:    tag_nxt[7:0]   = i_data;
                5'd1:    tag_nxt[15:8]  = i_data;
                5'd2:    chan_nxt[7:0]  = i_data;
                5'd3:    chan_nxt[15:8] = i_data;
                5'd4:    rate_nxt[7:0]  = i_data;
                5'd5:    rate_nxt[15:8] = i_data;
                5'd6:    rate_nxt[23:16] = i_data;
                5'd7:    rate_nxt[31:24] = i_data;
                5'd14:   bits_nxt[7:0]  = i_data;
                5'd15:   bits_nxt[15:8] = i_data;
                default: ;
              endcase
              if (off != 5'd16) off_nxt = off + 5'd1;
              remain_nxt = remain - 32'd1;
              // Validation uses the post-byte values: the last body byte may be the bits MSB.
              if (remain == 32'd1) begin
                if (tag_nxt != 16'd1 ||
                    !(chan_nxt == 16'd1 || chan_nxt == 16'd2) ||
                    !(bits_nxt == 16'd8 || bits_nxt == 16'd16)) begin
                  state_nxt = ERR;
                  err_nxt   = ERR_UNSUP;
                end else begin
                  fmt_seen_nxt = 1'b1;
                  state_nxt    = odd ? PAD : CK_ID;
                end
              end
            end
            SKIP: begin
              remain_nxt = remain - 32'd1;
              if (remain == 32'd1) state_nxt = odd ? PAD : CK_ID;
            end
            PAD:     state_nxt = CK_ID;
            default: ;
          endcase
          // Every field starts on byte 0.
          if (state_nxt != state) idx_nxt = '0;
        end
      end
      // The byte in the same cycle is processed first; only a still-open parse is truncated.
      if (i_end && parsing && state_nxt != DONE && state_nxt != ERR) begin
        state_nxt = ERR;
        err_nxt   = ERR_TRUNC;
      end
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    o_busy  = parsing;
    o_valid = (state == DONE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      exp_addr     <= '0;
      sh           <= '0;
      idx          <= '0;
      remain       <= '0;
      off          <= '0;
      odd          <= 1'b0;
      ck_id        <= '0;
      tag          <= '0;
      fmt_seen     <= 1'b0;
      o_error      <= ERR_NONE;
      o_channels   <= '0;
      o_rate       <= '0;
      o_bits       <= '0;
      o_data_start <= '0;
      o_data_len   <= '0;
    end else begin
      exp_addr     <= exp_nxt;
      sh           <= sh_nxt;
      idx          <= idx_nxt;
      remain       <= remain_nxt;
      off          <= off_nxt;
      odd          <= odd_nxt;
      ck_id        <= ck_id_nxt;
      tag          <= tag_nxt;
      fmt_seen     <= fmt_seen_nxt;
      o_error      <= err_nxt;
      o_channels   <= chan_nxt;
      o_rate       <= rate_nxt;
      o_bits       <= bits_nxt;
      o_data_start <= start_nxt;
      o_data_len   <= len_nxt;
    end
  end

endmodule

// File: tb/tb_wav_header_parser.sv
// Directed bench for wav_header_parser: builds headers byte by byte and checks parsed fields and error codes.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 time unit after the next edge.
// Backpressure: none; bytes are streamed back to back.
module tb_wav_header_parser;

  localparam int ADDR_W = 25;

  logic              clk_sys = 1'b0;
  logic              reset   = 1'b1;
  logic              i_start = 1'b0;
  logic              i_end   = 1'b0;
  logic              i_wr    = 1'b0;
  logic [ADDR_W-1:0] i_addr  = '0;
  logic [7:0]        i_data  = '0;
  logic              o_busy;
  logic              o_valid;
  logic [2:0]        o_error;
  logic [15:0]       o_channels;
  logic [31:0]       o_rate;
  logic [15:0]       o_bits;
  logic [ADDR_W-1:0] o_data_start;
  logic [31:0]       o_data_len;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] hdr [0:127];
  int         hlen;

  wav_header_parser #(.ADDR_W(ADDR_W)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .i_start      (i_start),
    .i_end        (i_end),
    .i_wr         (i_wr),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_error      (o_error),
    .o_channels   (o_channels),
    .o_rate       (o_rate),
    .o_bits       (o_bits),
    .o_data_start (o_data_start),
    .o_data_len   (o_data_len)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    i_wr   = 1'b1;
    i_addr = ADDR_W'(a);
    i_data = d;
    step();
    i_wr   = 1'b0;
  endtask

  task automatic send(input int first, input int last);
    for (int i = first; i <= last; i++) wr(i, hdr[i]);
  endtask

  task automatic h_b(input logic [7:0] b);
    hdr[hlen] = b;
    hlen++;
  endtask

  task automatic h_s(input string s);
    for (int i = 0; i < 4; i++) h_b(s[i]);
  endtask

  task automatic h_16(input logic [15:0] v);
    h_b(v[7:0]);
    h_b(v[15:8]);
  endtask

  task automatic h_32(input logic [31:0] v);
    h_16(v[15:0]);
    h_16(v[31:16]);
  endtask

  // RIFF/WAVE + 16-byte fmt (+ optional 5-byte LIST and pad) + data header of size 0x1000.
  task automatic build(input logic [15:0] tag, input logic [15:0] bits, input bit with_list);
    hlen = 0;
    h_s("RIFF"); h_32(32'd36 + 32'h1000); h_s("WAVE");
    h_s("fmt "); h_32(32'd16);
    h_16(tag); h_16(16'd2); h_32(32'd22050); h_32(32'd88200); h_16(16'd4); h_16(bits);
    if (with_list) begin
      h_s("LIST"); h_32(32'd5);
      for (int i = 0; i < 5; i++) h_b(8'hA0 + 8'(i));
      h_b(8'h00);
    end
    h_s("data"); h_32(32'h1000);
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_busy",  o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_error", o_error, 0);
    chk("rst_chan",  o_channels, 0);
    chk("rst_rate",  o_rate, 0);
    chk("rst_bits",  o_bits, 0);
    chk("rst_start", o_data_start, 0);
    chk("rst_len",   o_data_len, 0);
    reset = 1'b0;
    step();

    // Bytes in IDLE are ignored
    wr(0, 8'h52);
    chk("idle_busy", o_busy, 0);

    // Canonical 44-byte header
    build(16'd1, 16'd16, 1'b0);
    pulse_start();
    chk("can_busy0", o_busy, 1);
    send(0, 42);
    chk("can_valid_early", o_valid, 0);
    chk("can_chan",  o_channels, 2);
    chk("can_rate",  o_rate, 22050);
    chk("can_bits",  o_bits, 16);
    send(43, 43);
    chk("can_valid", o_valid, 1);
    chk("can_busy",  o_busy, 0);
    chk("can_start", o_data_start, 44);
    chk("can_len",   o_data_len, 32'h1000);
    chk("can_error", o_error, 0);
    wr(44, 8'h12); wr(99, 8'h34);
    chk("can_sample_ignored", o_valid, 1);

    // LIST chunk with odd size and pad byte
    build(16'd1, 16'd16, 1'b1);
    pulse_start();
    chk("list_cleared", o_valid, 0);
    send(0, hlen - 1);
    chk("list_valid", o_valid, 1);
    chk("list_start", o_data_start, 58);

    // RIFX
    build(16'd1, 16'd16, 1'b0);
    hdr[3] = "X";
    pulse_start();
    send(0, 2);
    chk("rifx_pre", o_error, 0);
    send(3, 3);
    chk("rifx_err",  o_error, 1);
    chk("rifx_busy", o_busy, 0);

    // WAVX
    build(16'd1, 16'd16, 1'b0);
    hdr[11] = "X";
    pulse_start();
    chk("wavx_clear", o_error, 0);
    send(0, 11);
    chk("wavx_err", o_error, 2);

    // data chunk before fmt
    hlen = 0;
    h_s("RIFF"); h_32(32'd100); h_s("WAVE"); h_s("data"); h_32(32'h10);
    pulse_start();
    send(0, 19);
    chk("nofmt_err",   o_error, 5);
    chk("nofmt_valid", o_valid, 0);

    // Float format
    build(16'd3, 16'd16, 1'b0);
    pulse_start();
    send(0, 34);
    chk("float_pre", o_error, 0);
    send(35, 35);
    chk("float_err", o_error, 6);

    // 24-bit samples
    build(16'd1, 16'd24, 1'b0);
    pulse_start();
    send(0, 35);
    chk("bits24_err", o_error, 6);

    // Address gap 10 -> 12
    build(16'd1, 16'd16, 1'b0);
    pulse_start();
    send(0, 10);
    wr(12, hdr[12]);
    chk("gap_err", o_error, 3);

    // Truncated after byte 30, then a clean restart
    pulse_start();
    send(0, 30);
    i_end = 1'b1;
    step();
    i_end = 1'b0;
    chk("trunc_err",  o_error, 7);
    chk("trunc_busy", o_busy, 0);
    pulse_start();
    chk("restart_clr", o_error, 0);
    send(0, 43);
    chk("restart_valid", o_valid, 1);
    chk("restart_err",   o_error, 0);

    // i_end together with the last data-size byte gives DONE
    pulse_start();
    send(0, 42);
    i_end = 1'b1;
    wr(43, hdr[43]);
    i_end = 1'b0;
    chk("end_last_valid", o_valid, 1);
    chk("end_last_err",   o_error, 0);

    // i_start together with i_wr drops the byte
    i_start = 1'b1;
    wr(0, 8'hEE);
    i_start = 1'b0;
    send(0, 43);
    chk("start_wr_valid", o_valid, 1);

    // Reset mid-parse
    pulse_start();
    send(0, 23);
    chk("mid_chan", o_channels, 2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_chan", o_channels, 0);
    step();
    reset = 1'b0;
    send(24, 43);
    chk("mid_ignored_valid", o_valid, 0);
    chk("mid_ignored_start", o_data_start, 0);
    pulse_start();
    send(0, 43);
    chk("mid_restart_valid", o_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
